// File: rtl/ad936x_pkg.sv
// Shared types and defaults for the ad936x ENSM pin sequencer.
// Holds the state encoding, default timing and command payload values.
package ad936x_pkg;

  typedef enum logic [2:0] {
    ALERT,
    SETUP,
    SETTLE,
    STREAMING,
    STOP
  } ensm_state_t;

  localparam int TXNRX_SETUP_CYCLES_DEFAULT = 8;
  localparam int SETTLE_CYCLES_DEFAULT      = 1024;
  localparam int MIN_DWELL_CYCLES_DEFAULT   = 64;
  localparam int WATCHDOG_CYCLES_DEFAULT    = 256;

  localparam logic CMD_ENABLE  = 1'b1;
  localparam logic CMD_DISABLE = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ad936x_clk_watchdog.sv
// Detects a stalled data clock feedback: counts cycles without a toggle while active
// and raises expire on the last allowed cycle.
module ad936x_clk_watchdog #(
  parameter int WATCHDOG_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_fb,
  input  logic active,
  output logic expire
);

  localparam int CNT_W = $clog2(WATCHDOG_CYCLES + 1);

  generate
    if (WATCHDOG_CYCLES < 2) begin : g_bad_watchdog
      $error("WATCHDOG_CYCLES must be >= 2");
    end
  endgenerate

  logic             fb_q;
  logic [CNT_W-1:0] cnt;
  logic             toggle;

  assign toggle = (clk_fb != fb_q);
  assign expire = active && !toggle && (cnt == CNT_W'(WATCHDOG_CYCLES - 1));

  // Held at zero while inactive, so entering SETTLE always starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_q <= 1'b0;
      cnt  <= '0;
    end else begin
      fb_q <= clk_fb;
      if (!active || toggle) begin
        cnt <= '0;
      end else if (!expire) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ad936x_ensm_controller.sv
// Level pin-control FDD sequencer for the ad936x ENSM: drives ENABLE/TXNRX,
// gates the sample streams after settling, and falls back to ALERT on a stalled data clock.
module ad936x_ensm_controller
  import ad936x_pkg::*;
#(
  parameter int TXNRX_SETUP_CYCLES = TXNRX_SETUP_CYCLES_DEFAULT,
  parameter int SETTLE_CYCLES      = SETTLE_CYCLES_DEFAULT,
  parameter int MIN_DWELL_CYCLES   = MIN_DWELL_CYCLES_DEFAULT,
  parameter int WATCHDOG_CYCLES    = WATCHDOG_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_enable,
  output logic cmd_ready,
  input  logic ad936x_data_clk_fb,
  output logic ad936x_enable,
  output logic ad936x_txnrx,
  output logic rx_stream_en,
  output logic tx_stream_en,
  output logic streaming,
  output logic fault
);

  localparam int CNT_MAX = max_int(max_int(TXNRX_SETUP_CYCLES, SETTLE_CYCLES),
                                   max_int(MIN_DWELL_CYCLES, WATCHDOG_CYCLES));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  generate
    if (TXNRX_SETUP_CYCLES < 1 || SETTLE_CYCLES < 1 || MIN_DWELL_CYCLES < 1) begin : g_bad_timing
      $error("TXNRX_SETUP_CYCLES, SETTLE_CYCLES and MIN_DWELL_CYCLES must be >= 1");
    end
  endgenerate

  ensm_state_t      state;
  logic [CNT_W-1:0] dwell;
  logic             wd_active;
  logic             wd_expire;
  logic             accept;

  assign wd_active = (state == SETTLE) || (state == STREAMING);
  assign cmd_ready = (state == ALERT) || ((state == STREAMING) && !wd_expire);
  assign accept    = cmd_valid && cmd_ready;

  ad936x_clk_watchdog #(
    .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
  ) u_clk_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_fb (ad936x_data_clk_fb),
    .active (wd_active),
    .expire (wd_expire)
  );

  // Each dwell state loads N-1 on entry and leaves on the edge where the count is zero,
  // so its output levels persist for exactly N edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ALERT;
      dwell         <= '0;
      ad936x_enable <= 1'b0;
      ad936x_txnrx  <= 1'b0;
      rx_stream_en  <= 1'b0;
      tx_stream_en  <= 1'b0;
      streaming     <= 1'b0;
      fault         <= 1'b0;
    end else begin
      case (state)
        ALERT: begin
          if (accept && (cmd_enable == CMD_ENABLE)) begin
            state        <= SETUP;
            dwell        <= CNT_W'(TXNRX_SETUP_CYCLES - 1);
            ad936x_txnrx <= 1'b1;
            fault        <= 1'b0;
          end
        end

        SETUP: begin
          if (dwell == '0) begin
            state         <= SETTLE;
            dwell         <= CNT_W'(SETTLE_CYCLES - 1);
            ad936x_enable <= 1'b1;
          end else begin
            dwell <= dwell - CNT_W'(1);
          end
        end

        SETTLE: begin
          if (wd_expire) begin
            state         <= STOP;
            dwell         <= CNT_W'(MIN_DWELL_CYCLES - 1);
            ad936x_enable <= 1'b0;
            fault         <= 1'b1;
          end else if (dwell == '0) begin
            state        <= STREAMING;
            rx_stream_en <= 1'b1;
            tx_stream_en <= 1'b1;
            streaming    <= 1'b1;
          end else begin
            dwell <= dwell - CNT_W'(1);
          end
        end

        STREAMING: begin
          // An expiring watchdog wins over a command offered on the same cycle.
          if (wd_expire || (accept && (cmd_enable == CMD_DISABLE))) begin
            state         <= STOP;
            dwell         <= CNT_W'(MIN_DWELL_CYCLES - 1);
            ad936x_enable <= 1'b0;
            rx_stream_en  <= 1'b0;
            tx_stream_en  <= 1'b0;
            streaming     <= 1'b0;
            if (wd_expire) begin
              fault <= 1'b1;
            end
          end
        end

        STOP: begin
          if (dwell == '0) begin
            state        <= ALERT;
            ad936x_txnrx <= 1'b0;
          end else begin
            dwell <= dwell - CNT_W'(1);
          end
        end

        default: begin
          state         <= ALERT;
          dwell         <= '0;
          ad936x_enable <= 1'b0;
          ad936x_txnrx  <= 1'b0;
          rx_stream_en  <= 1'b0;
          tx_stream_en  <= 1'b0;
          streaming     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad936x_ensm_controller.sv
// Directed bench for ad936x_ensm_controller: enable/disable sequencing, no-op commands,
// watchdog in STREAMING and SETTLE, and asynchronous reset.
module tb_ad936x_ensm_controller;

  localparam int PH_ALERT  = 0;
  localparam int PH_SETUP  = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_STREAM = 3;
  localparam int PH_STOP   = 4;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_enable;
  logic cmd_ready, ad936x_enable, ad936x_txnrx, rx_stream_en, tx_stream_en, streaming, fault;
  logic cmd_valid2, cmd_enable2;
  logic cmd_ready2, ad936x_enable2, ad936x_txnrx2, rx_stream_en2, tx_stream_en2, streaming2, fault2;
  logic fb_hold = 1'b0;

  logic fb_run;
  logic fb_manual;
  logic fb_auto = 1'b0;
  int   fb_div  = 0;
  logic clk_fb;

  assign clk_fb = fb_auto ^ fb_manual;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fb_run) begin
      fb_div = fb_div + 1;
      if (fb_div == 4) begin
        fb_div  = 0;
        fb_auto = ~fb_auto;
      end
    end
  end

  // ---------------- DUTs ----------------
  ad936x_ensm_controller #(
    .TXNRX_SETUP_CYCLES(4), .SETTLE_CYCLES(16), .MIN_DWELL_CYCLES(8), .WATCHDOG_CYCLES(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_enable(cmd_enable),
    .cmd_ready(cmd_ready), .ad936x_data_clk_fb(clk_fb), .ad936x_enable(ad936x_enable),
    .ad936x_txnrx(ad936x_txnrx), .rx_stream_en(rx_stream_en), .tx_stream_en(tx_stream_en),
    .streaming(streaming), .fault(fault)
  );

  // Long settle so a stalled clock from SETTLE entry expires before STREAMING is due.
  ad936x_ensm_controller #(
    .TXNRX_SETUP_CYCLES(4), .SETTLE_CYCLES(48), .MIN_DWELL_CYCLES(8), .WATCHDOG_CYCLES(32)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_enable(cmd_enable2),
    .cmd_ready(cmd_ready2), .ad936x_data_clk_fb(fb_hold), .ad936x_enable(ad936x_enable2),
    .ad936x_txnrx(ad936x_txnrx2), .rx_stream_en(rx_stream_en2), .tx_stream_en(tx_stream_en2),
    .streaming(streaming2), .fault(fault2)
  );

  logic [6:0] pins, pins2;
  assign pins  = {cmd_ready, fault, streaming, tx_stream_en, rx_stream_en, ad936x_txnrx, ad936x_enable};
  assign pins2 = {cmd_ready2, fault2, streaming2, tx_stream_en2, rx_stream_en2, ad936x_txnrx2, ad936x_enable2};

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run = tests_run + 1;
    if (obs !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // {cmd_ready, fault, streaming, tx_stream_en, rx_stream_en, txnrx, enable}
  function automatic logic [6:0] ev(input int ph, input logic f);
    case (ph)
      PH_ALERT:  return {1'b1, f, 5'b00000};
      PH_SETUP:  return {1'b0, f, 5'b00010};
      PH_SETTLE: return {1'b0, f, 5'b00011};
      PH_STREAM: return {1'b1, f, 5'b11111};
      default:   return {1'b0, f, 5'b00010};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send_cmd(input logic en, input logic exp_ready);
    cmd_valid  = 1'b1;
    cmd_enable = en;
    check("cmd_ready", {7'b0, cmd_ready}, {7'b0, exp_ready});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic [6:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, {1'b0, pins}, {1'b0, e});
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic ever_streamed;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_enable  = 1'b0;
    cmd_valid2  = 1'b0;
    cmd_enable2 = 1'b0;
    fb_run      = 1'b0;
    fb_manual   = 1'b0;

    repeat (3) @(negedge clk);
    check("reset", {1'b0, pins}, {1'b0, ev(PH_ALERT, 1'b0)});
    check("reset2", {1'b0, pins2}, {1'b0, ev(PH_ALERT, 1'b0)});
    rst_n = 1'b1;
    @(negedge clk);
    check("alert_idle", {1'b0, pins}, {1'b0, ev(PH_ALERT, 1'b0)});
    fb_run = 1'b1;

    // Enable: SETUP T+1..T+4, SETTLE T+5..T+20, STREAMING from T+21
    send_cmd(1'b1, 1'b1);
    for (int k = 1; k <= 21; k++) begin
      if (k <= 4)       exp_q.push_back(ev(PH_SETUP, 1'b0));
      else if (k <= 20) exp_q.push_back(ev(PH_SETTLE, 1'b0));
      else              exp_q.push_back(ev(PH_STREAM, 1'b0));
    end
    drain("enable_seq");

    // Enable while streaming is a no-op
    send_cmd(1'b1, 1'b1);
    for (int k = 0; k < 50; k++) begin
      check("noop_stream", {1'b0, pins}, {1'b0, ev(PH_STREAM, 1'b0)});
      @(negedge clk);
    end

    // Disable: STOP T+1..T+8, ALERT at T+9
    send_cmd(1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) exp_q.push_back(ev(PH_STOP, 1'b0));
    exp_q.push_back(ev(PH_ALERT, 1'b0));
    drain("disable_seq");

    // Disable while in ALERT is a no-op
    @(negedge clk);
    send_cmd(1'b0, 1'b1);
    for (int k = 0; k < 50; k++) begin
      check("noop_alert", {1'b0, pins}, {1'b0, ev(PH_ALERT, 1'b0)});
      @(negedge clk);
    end

    // Watchdog in STREAMING: one last toggle at N1, then the clock holds
    send_cmd(1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("wd_streaming", {1'b0, pins}, {1'b0, ev(PH_STREAM, 1'b0)});
    fb_run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    fb_manual = ~fb_manual;
    repeat (31) @(negedge clk);
    check("wd_before", {1'b0, pins}, {1'b0, ev(PH_STREAM, 1'b0)});
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_enable = 1'b0;
    check("wd_expire_ready", {7'b0, cmd_ready}, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wd_fault_edge", {1'b0, pins}, {1'b0, ev(PH_STOP, 1'b1)});
    repeat (7) @(negedge clk);
    check("wd_stop_end", {1'b0, pins}, {1'b0, ev(PH_STOP, 1'b1)});
    @(negedge clk);
    check("wd_alert", {1'b0, pins}, {1'b0, ev(PH_ALERT, 1'b1)});

    // Next enable clears the fault
    fb_run = 1'b1;
    @(negedge clk);
    send_cmd(1'b1, 1'b1);
    check("fault_clear", {1'b0, pins}, {1'b0, ev(PH_SETUP, 1'b0)});

    // Asynchronous reset mid-SETTLE, away from any clock edge
    repeat (9) @(negedge clk);
    check("mid_settle", {1'b0, pins}, {1'b0, ev(PH_SETTLE, 1'b0)});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {1'b0, pins}, {1'b0, ev(PH_ALERT, 1'b0)});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", {1'b0, pins}, {1'b0, ev(PH_ALERT, 1'b0)});

    // Watchdog in SETTLE on dut2: clock never toggles
    cmd_valid2  = 1'b1;
    cmd_enable2 = 1'b1;
    check("settle_wd_ready", {7'b0, cmd_ready2}, 8'h01);
    @(negedge clk);
    cmd_valid2    = 1'b0;
    ever_streamed = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (streaming2) ever_streamed = 1'b1;
      if (k == 5)  check("settle_wd_entry", {1'b0, pins2}, {1'b0, ev(PH_SETTLE, 1'b0)});
      if (k == 36) check("settle_wd_before", {1'b0, pins2}, {1'b0, ev(PH_SETTLE, 1'b0)});
      if (k == 37) check("settle_wd_fault", {1'b0, pins2}, {1'b0, ev(PH_STOP, 1'b1)});
      if (k == 45) check("settle_wd_alert", {1'b0, pins2}, {1'b0, ev(PH_ALERT, 1'b1)});
      if (k < 45) @(negedge clk);
    end
    check("settle_wd_no_stream", {7'b0, ever_streamed}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
